// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter
//   Shares one functional unit between NUM_REQ reservation-station issue
//   requesters using round-robin arbitration. Each operation runs through an
//   ISSUE phase (one cycle) and an optional WAIT phase. On completion the
//   result is broadcast once as {rob_idx, value}. A flush drops any op that is
//   in flight. A WAIT that lasts too long sets a sticky timeout flag.
//
// Ports
//   in_clk          clock, rising edge
//   in_rst          synchronous active-low reset
//   in_req          per-requester ready-to-issue
//   in_req_rob_idx  per-requester ROB tag, slot i at [i*ROB_IDX_W +: ROB_IDX_W]
//   in_fu_done      FU result valid (pulse)
//   in_fu_value     FU result
//   in_flush        mispredict flush
//   out_grant       one-hot grant pulse
//   out_fu_start    FU start pulse, coincident with out_grant
//   out_fu_rob_idx  tag of the op in flight
//   out_busy        high while in ISSUE or WAIT
//   out_cdb_valid   broadcast valid pulse
//   out_cdb_rob_idx broadcast tag (held until the next broadcast)
//   out_cdb_value   broadcast value (held until the next broadcast)
//   out_timeout     sticky WAIT timeout flag, cleared only by reset
module fu_issue_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ROB_IDX_W = 6,
    parameter int VAL_W     = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic [NUM_REQ-1:0]           in_req,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] in_req_rob_idx,
    input  logic                         in_fu_done,
    input  logic [VAL_W-1:0]             in_fu_value,
    input  logic                         in_flush,
    output logic [NUM_REQ-1:0]           out_grant,
    output logic                         out_fu_start,
    output logic [ROB_IDX_W-1:0]         out_fu_rob_idx,
    output logic                         out_busy,
    output logic                         out_cdb_valid,
    output logic [ROB_IDX_W-1:0]         out_cdb_rob_idx,
    output logic [VAL_W-1:0]             out_cdb_value,
    output logic                         out_timeout
);

    localparam int unsigned NREQ = NUM_REQ;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   start_q, start_d;
    logic [ROB_IDX_W-1:0]   fu_idx_q, fu_idx_d;
    logic                   cdb_valid_q, cdb_valid_d;
    logic [ROB_IDX_W-1:0]   cdb_idx_q, cdb_idx_d;
    logic [VAL_W-1:0]       cdb_value_q, cdb_value_d;
    logic                   timeout_q, timeout_d;

    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    logic                   any_req;
    logic [PW-1:0]          win_idx;
    logic [PW-1:0]          win_next_ptr;
    logic [ROB_IDX_W-1:0]   win_tag;

    always_comb begin
        int unsigned idx;
        any_req      = 1'b0;
        win_idx      = '0;
        win_next_ptr = rr_ptr_q;
        idx          = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!any_req && in_req[idx]) begin
                any_req      = 1'b1;
                win_idx      = PW'(idx);
                win_next_ptr = PW'((idx + 1) % NREQ);
            end
        end
        win_tag = in_req_rob_idx[win_idx*ROB_IDX_W +: ROB_IDX_W];
    end

    always_comb begin
        logic launch;
        logic complete;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        grant_d     = '0;
        start_d     = 1'b0;
        fu_idx_d    = fu_idx_q;
        cdb_valid_d = 1'b0;
        cdb_idx_d   = cdb_idx_q;
        cdb_value_d = cdb_value_q;
        timeout_d   = timeout_q;
        launch      = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                launch = any_req && !in_flush;
            end
            S_ISSUE: begin
                if (in_flush) begin
                    state_d = S_IDLE;
                end else if (in_fu_done) begin
                    // Combinational FU: complete without entering WAIT.
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (in_flush) begin
                    state_d = S_IDLE;
                end else if (in_fu_done) begin
                    complete = 1'b1;
                    if (any_req) launch = 1'b1;
                    else         state_d = S_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (complete) begin
            cdb_valid_d = 1'b1;
            cdb_idx_d   = fu_idx_q;
            cdb_value_d = in_fu_value;
        end

        if (launch) begin
            state_d           = S_ISSUE;
            grant_d[win_idx]  = 1'b1;
            start_d           = 1'b1;
            fu_idx_d          = win_tag;
            rr_ptr_d          = win_next_ptr;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            start_q     <= 1'b0;
            fu_idx_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_value_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            start_q     <= start_d;
            fu_idx_q    <= fu_idx_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_idx_q   <= cdb_idx_d;
            cdb_value_q <= cdb_value_d;
            timeout_q   <= timeout_d;
        end
    end

    assign out_grant       = grant_q;
    assign out_fu_start    = start_q;
    assign out_fu_rob_idx  = fu_idx_q;
    assign out_busy        = (state_q != S_IDLE);
    assign out_cdb_valid   = cdb_valid_q;
    assign out_cdb_rob_idx = cdb_idx_q;
    assign out_cdb_value   = cdb_value_q;
    assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter
//   Drives fu_issue_arbiter with directed sequences and random traffic and
//   compares every output each cycle against an operation-level model.
module tb_fu_issue_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 6;
    localparam int VW   = 32;
    localparam int TO   = 16;

    logic                 in_clk = 1'b0;
    logic                 in_rst = 1'b0;
    logic [NREQ-1:0]      in_req = '0;
    logic [NREQ*IW-1:0]   in_req_rob_idx = '0;
    logic                 in_fu_done = 1'b0;
    logic [VW-1:0]        in_fu_value = '0;
    logic                 in_flush = 1'b0;
    logic [NREQ-1:0]      out_grant;
    logic                 out_fu_start;
    logic [IW-1:0]        out_fu_rob_idx;
    logic                 out_busy;
    logic                 out_cdb_valid;
    logic [IW-1:0]        out_cdb_rob_idx;
    logic [VW-1:0]        out_cdb_value;
    logic                 out_timeout;

    fu_issue_arbiter #(
        .NUM_REQ  (NREQ),
        .ROB_IDX_W(IW),
        .VAL_W    (VW),
        .TIMEOUT  (TO)
    ) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_req         (in_req),
        .in_req_rob_idx (in_req_rob_idx),
        .in_fu_done     (in_fu_done),
        .in_fu_value    (in_fu_value),
        .in_flush       (in_flush),
        .out_grant      (out_grant),
        .out_fu_start   (out_fu_start),
        .out_fu_rob_idx (out_fu_rob_idx),
        .out_busy       (out_busy),
        .out_cdb_valid  (out_cdb_valid),
        .out_cdb_rob_idx(out_cdb_rob_idx),
        .out_cdb_value  (out_cdb_value),
        .out_timeout    (out_timeout)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Operation-level model: is an op outstanding, is it still in its issue
    // cycle, how many wait cycles it has used, and who is next in line.
    bit              m_busy, m_first, e_start, e_cdbv, e_timeout;
    int              m_waited, m_rr;
    logic [NREQ-1:0] e_grant;
    logic [IW-1:0]   e_fuidx, e_cdbidx;
    logic [VW-1:0]   e_cdbval;

    task automatic model_step(input logic rst, input logic [NREQ-1:0] req,
                              input logic [NREQ*IW-1:0] tags, input logic done,
                              input logic [VW-1:0] val, input logic flush);
        bit launch;
        int slot;
        if (!rst) begin
            m_busy = 0; m_first = 0; m_waited = 0; m_rr = 0;
            e_grant = '0; e_start = 0; e_fuidx = '0; e_cdbv = 0;
            e_cdbidx = '0; e_cdbval = '0; e_timeout = 0;
            return;
        end
        launch  = 0;
        e_grant = '0;
        e_start = 0;
        e_cdbv  = 0;
        if (!m_busy) begin
            launch = !flush && (req != 0);
        end else if (flush) begin
            m_busy = 0;
        end else if (done) begin
            e_cdbv   = 1;
            e_cdbidx = e_fuidx;
            e_cdbval = val;
            if (!m_first && req != 0) launch = 1;
            else                      m_busy = 0;
        end else if (m_first) begin
            m_first  = 0;
            m_waited = 0;
        end else begin
            m_waited++;
            if (m_waited == TO) begin
                e_timeout = 1;
                m_busy    = 0;
            end
        end
        if (launch) begin
            slot = -1;
            for (int k = 0; k < NREQ; k++)
                if (slot < 0 && req[(m_rr + k) % NREQ]) slot = (m_rr + k) % NREQ;
            e_grant = '0;
            e_grant[slot] = 1'b1;
            e_start = 1;
            e_fuidx = tags[slot*IW +: IW];
            m_rr    = (slot + 1) % NREQ;
            m_busy  = 1;
            m_first = 1;
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic [NREQ-1:0] req,
                               input logic [NREQ*IW-1:0] tags, input logic done,
                               input logic [VW-1:0] val, input logic flush);
        @(negedge in_clk);
        in_rst = rst; in_req = req; in_req_rob_idx = tags;
        in_fu_done = done; in_fu_value = val; in_flush = flush;
        model_step(rst, req, tags, done, val, flush);
        @(posedge in_clk);
        #1;
        check_eq("grant",    64'(out_grant),       64'(e_grant));
        check_eq("fu_start", 64'(out_fu_start),    64'(e_start));
        check_eq("fu_idx",   64'(out_fu_rob_idx),  64'(e_fuidx));
        check_eq("busy",     64'(out_busy),        64'(m_busy));
        check_eq("cdb_v",    64'(out_cdb_valid),   64'(e_cdbv));
        check_eq("cdb_idx",  64'(out_cdb_rob_idx), 64'(e_cdbidx));
        check_eq("cdb_val",  64'(out_cdb_value),   64'(e_cdbval));
        check_eq("timeout",  64'(out_timeout),     64'(e_timeout));
    endtask

    logic [NREQ*IW-1:0] tags;
    logic [VW-1:0]      rv;

    initial begin
        tags = {6'd13, 6'd5, 6'd22, 6'd41};   // slot3..slot0; slot 2 carries tag 5

        // Reset held with all requesting: nothing granted, everything zero.
        repeat (3) drive_cycle(1'b0, 4'b1111, tags, 1'b1, 32'h55, 1'b0);
        check_eq("rst_grant", 64'(out_grant), 64'h0);
        check_eq("rst_cdbv",  64'(out_cdb_valid), 64'h0);
        drive_cycle(1'b1, 4'b1111, tags, 1'b0, '0, 1'b0);
        check_eq("first_grant", 64'(out_grant), 64'b0001);

        // Round-robin with a combinational FU: grants 1,2,3,0 every other cycle.
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(1'b1, 4'b1111, tags, 1'b1, 32'(k), 1'b0);
            check_eq("rr_gap", 64'(out_grant), 64'h0);
            drive_cycle(1'b1, 4'b1111, tags, 1'b0, '0, 1'b0);
            check_eq("rr_grant", 64'(out_grant), 64'(1 << (k % 4)));
        end
        drive_cycle(1'b1, 4'b0000, tags, 1'b1, 32'h7, 1'b0);

        // Multi-cycle op: slot 2, tag 5, done three cycles after the grant.
        drive_cycle(1'b1, 4'b0100, tags, 1'b0, '0, 1'b0);
        check_eq("mc_grant", 64'(out_grant), 64'b0100);
        check_eq("mc_tag",   64'(out_fu_rob_idx), 64'd5);
        drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 4'b0000, tags, 1'b1, 32'hFFF, 1'b0);
        check_eq("mc_cdbv",  64'(out_cdb_valid), 64'h1);
        check_eq("mc_cdbix", 64'(out_cdb_rob_idx), 64'd5);
        check_eq("mc_cdbvl", 64'(out_cdb_value), 64'hFFF);

        // Back-to-back: done in WAIT with another slot requesting issues at once.
        drive_cycle(1'b1, 4'b1010, tags, 1'b0, '0, 1'b0);
        check_eq("b2b_g0", 64'(out_grant), 64'b1000);
        drive_cycle(1'b1, 4'b1010, tags, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 4'b1010, tags, 1'b1, 32'hABC, 1'b0);
        check_eq("b2b_g1",   64'(out_grant), 64'b0010);
        check_eq("b2b_busy", 64'(out_busy), 64'h1);
        check_eq("b2b_cdbv", 64'(out_cdb_valid), 64'h1);
        drive_cycle(1'b1, 4'b0000, tags, 1'b1, 32'h123, 1'b0);

        // Flush: in IDLE blocks the grant; in WAIT drops the op and a same-cycle done.
        drive_cycle(1'b1, 4'b1111, tags, 1'b0, '0, 1'b1);
        check_eq("fl_idle", 64'(out_grant), 64'h0);
        drive_cycle(1'b1, 4'b1111, tags, 1'b0, '0, 1'b0);
        check_eq("fl_g0", 64'(out_grant), 64'b0100);
        drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 4'b0000, tags, 1'b1, 32'hDEAD, 1'b1);
        check_eq("fl_cdbv", 64'(out_cdb_valid), 64'h0);
        check_eq("fl_busy", 64'(out_busy), 64'h0);
        drive_cycle(1'b1, 4'b1111, tags, 1'b0, '0, 1'b0);
        check_eq("fl_rr", 64'(out_grant), 64'b1000);
        drive_cycle(1'b1, 4'b0000, tags, 1'b1, 32'h9, 1'b0);

        // Timeout: no done ever; fires after TO wait cycles and stays set.
        drive_cycle(1'b1, 4'b0001, tags, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        repeat (TO - 1) drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        check_eq("to_before", 64'(out_timeout), 64'h0);
        check_eq("to_busy",   64'(out_busy), 64'h1);
        drive_cycle(1'b1, 4'b0000, tags, 1'b0, '0, 1'b0);
        check_eq("to_set",  64'(out_timeout), 64'h1);
        check_eq("to_idle", 64'(out_busy), 64'h0);
        repeat (6) drive_cycle(1'b1, 4'($urandom), tags, 1'($urandom), 32'($urandom), 1'b0);
        check_eq("to_sticky", 64'(out_timeout), 64'h1);
        drive_cycle(1'b0, 4'b0000, tags, 1'b0, '0, 1'b0);
        check_eq("to_clear", 64'(out_timeout), 64'h0);

        // Random traffic with phases of different FU completion rates.
        for (int seg = 0; seg < 40; seg++) begin
            int done_pct;
            done_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 30 : 75);
            for (int c = 0; c < 64; c++) begin
                tags = NREQ*IW'({$urandom, $urandom});
                rv   = $urandom;
                drive_cycle(($urandom_range(0, 299) != 0),
                            ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
                            tags,
                            ($urandom_range(0, 99) < done_pct),
                            rv,
                            ($urandom_range(0, 19) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
